// File: rtl/spi_flash_bitstream_reader.sv
// rtl/spi_flash_bitstream_reader.sv - SPI flash read engine that streams the channel FPGA bitstream one bit per clk
// Optional build macro SPI_FAST_READ_EN: uses FAST_READ (8'h0B) with 8 dummy cycles instead of READ (8'h03).
module spi_flash_bitstream_reader #(
    parameter logic [23:0] START_ADDR     = 24'h000000,
    parameter logic [31:0] BIT_LENGTH     = 32'd0,
    parameter int          CS_HIGH_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic read_bitstream,
    output logic bitstream,
    output logic end_bitstream,
    output logic busy,
    output logic spi_cs_n,
    output logic spi_sck_en,
    output logic spi_mosi,
    input  logic spi_miso
);

`ifdef SPI_FAST_READ_EN
    localparam logic [7:0] READ_OPCODE = 8'h0B;
`else
    localparam logic [7:0] READ_OPCODE = 8'h03;
`endif

    localparam logic [3:0] CS_GAP = 4'(CS_HIGH_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_RELEASE
    } state_t;

    state_t      r_state;
    logic [3:0]  r_gap_cnt;
    logic [4:0]  r_shift_cnt;
    logic [31:0] r_bit_cnt;
    logic [31:0] r_shift;
    logic        r_cs_n;
    logic        r_sck_en;
    logic        r_mosi;
    logic        r_bitstream;
    logic        r_end;
    logic        r_busy;

    assign spi_cs_n      = r_cs_n;
    assign spi_sck_en    = r_sck_en;
    assign spi_mosi      = r_mosi;
    assign bitstream     = r_bitstream;
    assign end_bitstream = r_end;
    assign busy          = r_busy;

    // Transaction sequencer: opcode/address shift-out, optional dummy phase, data capture and release handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_gap_cnt   <= CS_GAP;
            r_shift_cnt <= 5'd0;
            r_bit_cnt   <= 32'd0;
            r_shift     <= 32'd0;
            r_cs_n      <= 1'b1;
            r_sck_en    <= 1'b0;
            r_mosi      <= 1'b0;
            r_bitstream <= 1'b1;
            r_end       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cs_n      <= 1'b1;
                    r_sck_en    <= 1'b0;
                    r_mosi      <= 1'b0;
                    r_bitstream <= 1'b1;
                    r_end       <= 1'b0;
                    if (r_gap_cnt != 4'hF) begin
                        r_gap_cnt <= r_gap_cnt + 4'd1;
                    end
                    if (read_bitstream && (r_gap_cnt >= CS_GAP)) begin
                        r_state     <= S_CMD;
                        r_busy      <= 1'b1;
                        r_cs_n      <= 1'b0;
                        r_sck_en    <= 1'b1;
                        r_mosi      <= READ_OPCODE[7];
                        r_shift     <= {READ_OPCODE[6:0], START_ADDR, 1'b0};
                        r_shift_cnt <= 5'd7;
                    end
                end

                S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
                    if (!read_bitstream) begin
                        // Requester gave up: deselect the flash at once, no end pulse
                        r_state     <= S_RELEASE;
                        r_cs_n      <= 1'b1;
                        r_sck_en    <= 1'b0;
                        r_mosi      <= 1'b0;
                        r_bitstream <= 1'b1;
                        r_end       <= 1'b0;
                        r_gap_cnt   <= 4'd0;
                    end else begin
                        case (r_state)
                            S_CMD: begin
                                // The last opcode edge already launches the first address bit
                                r_mosi  <= r_shift[31];
                                r_shift <= {r_shift[30:0], 1'b0};
                                if (r_shift_cnt == 5'd0) begin
                                    r_state     <= S_ADDR;
                                    r_shift_cnt <= 5'd23;
                                end else begin
                                    r_shift_cnt <= r_shift_cnt - 5'd1;
                                end
                            end
                            S_ADDR: begin
                                if (r_shift_cnt == 5'd0) begin
                                    r_mosi <= 1'b0;
`ifdef SPI_FAST_READ_EN
                                    r_state     <= S_DUMMY;
                                    r_shift_cnt <= 5'd7;
`else
                                    r_state   <= S_DATA;
                                    r_bit_cnt <= BIT_LENGTH - 32'd1;
`endif
                                end else begin
                                    r_mosi      <= r_shift[31];
                                    r_shift     <= {r_shift[30:0], 1'b0};
                                    r_shift_cnt <= r_shift_cnt - 5'd1;
                                end
                            end
                            S_DUMMY: begin
                                r_mosi <= 1'b0;
                                if (r_shift_cnt == 5'd0) begin
                                    r_state   <= S_DATA;
                                    r_bit_cnt <= BIT_LENGTH - 32'd1;
                                end else begin
                                    r_shift_cnt <= r_shift_cnt - 5'd1;
                                end
                            end
                            default: begin
                                // DATA: one registered flash bit per cycle; the final bit carries the end pulse
                                r_mosi      <= 1'b0;
                                r_bitstream <= spi_miso;
                                if (r_bit_cnt == 32'd0) begin
                                    r_state   <= S_RELEASE;
                                    r_end     <= 1'b1;
                                    r_cs_n    <= 1'b1;
                                    r_sck_en  <= 1'b0;
                                    r_gap_cnt <= 4'd0;
                                end else begin
                                    r_bit_cnt <= r_bit_cnt - 32'd1;
                                end
                            end
                        endcase
                    end
                end

                default: begin
                    // RELEASE: hold off until the request drops so a held level never retriggers
                    r_cs_n      <= 1'b1;
                    r_sck_en    <= 1'b0;
                    r_mosi      <= 1'b0;
                    r_bitstream <= 1'b1;
                    r_end       <= 1'b0;
                    r_gap_cnt   <= 4'd0;
                    if (!read_bitstream) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_bitstream_reader.sv
// tb/tb_spi_flash_bitstream_reader.sv - directed self-checking bench with a behavioural SPI flash
module tb_spi_flash_bitstream_reader;

`ifdef SPI_FAST_READ_EN
    localparam logic [7:0] EXP_OPCODE = 8'h0B;
    localparam int         HDR        = 40;
`else
    localparam logic [7:0] EXP_OPCODE = 8'h03;
    localparam int         HDR        = 32;
`endif
    localparam int          LAT      = HDR + 2;
    localparam logic [23:0] ADDR     = 24'h123456;
    localparam logic [15:0] EXP_BITS = 16'b1010_0101_0011_1100;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic read_bitstream = 1'b0;
    logic bitstream, end_bitstream, busy, spi_cs_n, spi_sck_en, spi_mosi;
    logic spi_miso = 1'b1;

    int n_checks = 0;
    int n_fail = 0;

    spi_flash_bitstream_reader #(
        .START_ADDR(ADDR),
        .BIT_LENGTH(32'd16),
        .CS_HIGH_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .read_bitstream(read_bitstream),
        .bitstream(bitstream),
        .end_bitstream(end_bitstream),
        .busy(busy),
        .spi_cs_n(spi_cs_n),
        .spi_sck_en(spi_sck_en),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    // flash model state and monitors
    int          cyc = 0;
    int          fl_n = 0;
    logic [7:0]  fl_cmd = 8'h00;
    logic [23:0] fl_addr = 24'h0;
    int          end_cnt = 0;
    int          rise_cyc = 0;
    int          fall_cyc = 0;
    logic        prev_cs = 1'b1;

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        if (a == 24'h123456) return 8'hA5;
        if (a == 24'h123457) return 8'h3C;
        return 8'hFF;
    endfunction

    always @(negedge clk) begin
        logic [7:0] b;
        int d;
        cyc = cyc + 1;
        if (spi_cs_n) begin
            fl_n = 0;
            spi_miso = 1'b1;
        end else begin
            fl_n = fl_n + 1;
            if (fl_n <= 8) fl_cmd = {fl_cmd[6:0], spi_mosi};
            else if (fl_n <= 32) fl_addr = {fl_addr[22:0], spi_mosi};
            if (fl_n >= HDR + 1) begin
                d = fl_n - HDR - 1;
                b = flash_byte(fl_addr + 24'(d / 8));
                spi_miso = b[7 - (d % 8)];
            end
        end
        if (end_bitstream) end_cnt = end_cnt + 1;
        if (!prev_cs && spi_cs_n) rise_cyc = cyc;
        if (prev_cs && !spi_cs_n) fall_cyc = cyc;
        prev_cs = spi_cs_n;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_cs_low(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!spi_cs_n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int cs_low;
        int busy_low;

        // reset state
        repeat (3) tick();
        check("reset_outs", 32'({spi_cs_n, spi_sck_en, spi_mosi, bitstream, end_bitstream, busy}), 32'b100100);
        reset = 1'b0;
        tick();

        // main read, request held
        read_bitstream = 1'b1;
        for (int k = 1; k <= LAT + 15; k++) begin
            tick();
            if (k == 1) check("cs_fall_first", 32'(spi_cs_n), 32'd0);
            if (k >= LAT) check("bit", 32'(bitstream), 32'(EXP_BITS[15 - (k - LAT)]));
            if (k == LAT + 14) check("pre_last", 32'({end_bitstream, spi_cs_n}), 32'b00);
            if (k == LAT + 15) check("last", 32'({end_bitstream, spi_cs_n, spi_sck_en}), 32'b110);
        end
        check("opcode", 32'(fl_cmd), 32'(EXP_OPCODE));
        check("address", 32'(fl_addr), 32'(ADDR));
        tick();
        check("end_single", 32'(end_bitstream), 32'd0);

        // held request must not retrigger
        cs_low = 0;
        busy_low = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (!spi_cs_n) cs_low++;
            if (!busy) busy_low++;
        end
        check("hold_no_cs", 32'(cs_low), 32'd0);
        check("hold_busy", 32'(busy_low), 32'd0);
        check("end_count1", 32'(end_cnt), 32'd1);
        read_bitstream = 1'b0;
        tick();
        check("busy_drop", 32'(busy), 32'd0);

        // re-request one cycle after IDLE: CS gap respected
        tick();
        read_bitstream = 1'b1;
        wait_cs_low(ok);
        check("cs_fall_rereq", 32'(ok), 32'd1);
        tick();
        check("cs_gap", 32'((fall_cyc - rise_cyc) >= 4), 32'd1);

        // abort in cycle 10 of ADDR
        repeat (16) tick();
        read_bitstream = 1'b0;
        tick();
        check("abort_cs", 32'({spi_cs_n, spi_sck_en}), 32'b10);
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        repeat (5) tick();
        check("abort_no_end", 32'(end_cnt), 32'd1);

        // reset during DATA at bit 5
        repeat (3) tick();
        read_bitstream = 1'b1;
        wait_cs_low(ok);
        check("cs_fall_rst", 32'(ok), 32'd1);
        repeat (LAT - 1 + 5) tick();
        reset = 1'b1;
        tick();
        check("midreset_outs", 32'({spi_cs_n, spi_sck_en, bitstream, busy}), 32'b1010);
        reset = 1'b0;
        check("midreset_no_end", 32'(end_cnt), 32'd1);
        wait_cs_low(ok);
        check("restart_cs", 32'(ok), 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (end_bitstream) begin
                ok = 1'b1;
                break;
            end
        end
        check("restart_end", 32'(ok), 32'd1);
        check("restart_opcode", 32'(fl_cmd), 32'(EXP_OPCODE));
        tick();
        check("end_count2", 32'(end_cnt), 32'd2);
        read_bitstream = 1'b0;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_flash_bitstream_reader.md
Name: spi_flash_bitstream_reader

Overview:
- Responder end of the channel-programming bitstream handshake: on `read_bitstream`, issues an SPI read to the configuration flash and streams the channel FPGA bitstream one bit per `clk` on `bitstream`.
- Pulses `end_bitstream` with the last bit.
- Sits between the channel programmer (slave-serial master) and the SPI flash pins.
- SPI clock forwarding (ODDR/STARTUP primitive) lives outside this block and is gated by `spi_sck_en`.

Parameters:
- START_ADDR, 24'h000000, flash byte address of the first bitstream bit.
- BIT_LENGTH, 32'd0, number of bitstream bits to stream. Legal range 1..2^32-1; 0 is illegal and the block must not be instantiated with it.
- CS_HIGH_CYCLES, 4, minimum `clk` cycles `spi_cs_n` stays high between transactions. Legal range 1..15.

Ports:
- clk  input  1  system clock; SPI clock is forwarded at the same rate.
- reset  input  1  synchronous, active-high reset.
- read_bitstream  input  1  level request from the channel programmer; held high for the whole load.
- bitstream  output  1  serial bitstream, MSB of each flash byte first. Idle value 1.
- end_bitstream  output  1  one-cycle pulse coincident with the last valid bit.
- busy  output  1  high in any state other than IDLE.
- spi_cs_n  output  1  flash chip select, active low.
- spi_sck_en  output  1  enable for the external forwarded SPI clock.
- spi_mosi  output  1  command/address to flash.
- spi_miso  input  1  data from flash.

Behaviour:
- Reset (sync, active-high) sets these values on the next rising `clk` edge, regardless of state:
  - state=IDLE; `spi_cs_n`=1, `spi_sck_en`=0, `spi_mosi`=0, `bitstream`=1, `end_bitstream`=0, `busy`=0.
  - CS-high counter preloaded to CS_HIGH_CYCLES, so a request right after reset waits the full gap.
- Reset mid-transaction: the flash is deselected on that edge and no `end_bitstream` is issued.
- State machine: IDLE -> CMD -> ADDR -> [DUMMY] -> DATA -> RELEASE -> IDLE.
- IDLE:
  - `cs_n`=1, `sck_en`=0; CS-high counter increments, saturating.
  - Go to CMD when `read_bitstream`=1 and counter >= CS_HIGH_CYCLES.
- CMD:
  - `cs_n`=0, `sck_en`=1.
  - Shifts out the 8-bit read opcode MSB-first on `spi_mosi`, one bit per clk, launched on the clk rising edge: 8 cycles.
- ADDR: 24 cycles shifting START_ADDR MSB-first.
- DATA:
  - `mosi`=0; bit counter runs from BIT_LENGTH-1 down to 0.
  - `spi_miso` is registered once into `bitstream`, so `bitstream` bit k appears one cycle after the k-th DATA cycle.
  - After the last DATA cycle, `cs_n`=1 and `sck_en`=0 on the next edge.
  - `end_bitstream`=1 for exactly the cycle in which the last bit is on `bitstream`.
- RELEASE:
  - `bitstream`=1; counter cleared to 0.
  - Wait until `read_bitstream`=0, then go to IDLE. A held request never retriggers a second read.
- `read_bitstream` dropping during CMD/ADDR/DATA aborts the transaction:
  - `cs_n`=1 and `sck_en`=0 next edge; go to RELEASE with no `end_bitstream`.
  - The abort exit from RELEASE is immediate, since `read_bitstream` is already low.
- Request latency: `read_bitstream` rise in IDLE (gap satisfied) to first data bit on `bitstream` = 1 (IDLE->CMD) + 8 + 24 [+8] + 1 cycles.
- Counters:
  - Bit counter is 32-bit.
  - Shift counter is 5-bit and reloads per phase.
  - No wrap of the flash address is handled: the flash's own wrap applies past top of device.
- `busy`=1 in CMD/ADDR/DUMMY/DATA/RELEASE.

Optional Feature:
- SPI_FAST_READ_EN defined:
  - Opcode 8'h0B (FAST_READ).
  - DUMMY state of 8 cycles after ADDR (`cs_n`=0, `sck_en`=1, `mosi`=0); first-bit latency grows by 8.
- Undefined:
  - Opcode 8'h03 (READ); no DUMMY state.

Test Plan:
- BIT_LENGTH=16, START_ADDR=24'h123456, flash model holds 8'hA5,8'h3C at that address; assert `read_bitstream` and hold it. Required:
  - `mosi` shows 8'h03 then 24'h123456.
  - `bitstream` = 1010_0101_0011_1100 on consecutive cycles starting 34 cycles after the request.
  - `end_bitstream` is a single pulse on the final 0.
  - `cs_n` rises the next cycle.
- Hold `read_bitstream` high 50 cycles after `end_bitstream`. Required:
  - No second `cs_n` fall; `busy`=1 throughout.
  - After release, `busy`=0 next cycle.
- Re-request 1 cycle after returning to IDLE with CS_HIGH_CYCLES=4 -> `cs_n` falls no earlier than 4 cycles after the previous rise.
- Drop `read_bitstream` in cycle 10 of ADDR -> `cs_n`=1 and `sck_en`=0 next edge; `end_bitstream` never pulses; `busy`=0 within 2 cycles.
- Assert `reset` during DATA at bit 5 -> next edge: `cs_n`=1, `sck_en`=0, `bitstream`=1, `busy`=0; a subsequent request restarts from CMD.
- With SPI_FAST_READ_EN: same data as the first test -> `mosi` opcode 8'h0B, 8 dummy cycles, first bit at cycle 42, identical bit sequence.
